// File: rtl/audio_codec_pkg.sv
// Shared types and constants for the WM8731 codec serial interfaces.
package audio_codec_pkg;

  typedef enum logic [1:0] {IDLE, DELAY, SHIFT, PAD} i2s_tx_state_t;

  localparam int SAMPLE_W       = 16;
  localparam int I2S_DATA_DELAY = 1;

endpackage

// File: rtl/edge_sync.sv
// Brings an asynchronous codec clock into the clk domain and produces
// one-clk rise/fall strobes from the synchronised level.
module edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // Synchroniser chain plus one history flop; nothing here needs a reset.
  always_ff @(posedge clk) begin
    r_sync <= {r_sync[STAGES-2:0], i_async};
    r_prev <= r_sync[STAGES-1];
  end

  assign o_rise = r_sync[STAGES-1] & ~r_prev;
  assign o_fall = r_prev & ~r_sync[STAGES-1];

endmodule

// File: rtl/dac_i2s_tx.sv
// I2S transmitter for the WM8731 DAC: one mono sample per frame, played on
// both slots, with the codec acting as bus master for BCLK and DACLRCK.
module dac_i2s_tx
  import audio_codec_pkg::*;
#(
  parameter int N           = SAMPLE_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                bclk,
  input  logic                daclrck,
  input  logic signed [N-1:0] sample_data,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                dacdat,
  output logic                frame_start,
  output logic                underrun
);

  localparam int CW = $clog2(N + 1);

  logic w_bclk_rise, w_bclk_fall;
  logic w_lr_rise, w_lr_fall;

  edge_sync #(.STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk    (clk),
    .i_async(bclk),
    .o_rise (w_bclk_rise),
    .o_fall (w_bclk_fall)
  );

  edge_sync #(.STAGES(SYNC_STAGES)) u_lr_sync (
    .clk    (clk),
    .i_async(daclrck),
    .o_rise (w_lr_rise),
    .o_fall (w_lr_fall)
  );

  i2s_tx_state_t       r_state;
  logic                r_hold_full;
  logic signed [N-1:0] r_hold_data;
  logic signed [N-1:0] r_frame;
  logic signed [N-1:0] r_shreg;
  logic [CW-1:0]       r_bit_cnt;
  logic                r_dacdat;
  logic                r_frame_start;
  logic                r_underrun;
  logic signed [N-1:0] w_load_word;
  logic                w_accept;

  assign sample_ready = ~r_hold_full;
  assign w_accept     = sample_valid & ~r_hold_full;
  // An empty hold at a left load plays silence rather than bypassing a same-cycle accept.
  assign w_load_word  = r_hold_full ? r_hold_data : '0;

  always_ff @(posedge clk) begin
    if (w_accept) r_hold_data <= sample_data;
    if (w_lr_fall) r_frame <= w_load_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_hold_full   <= 1'b0;
      r_shreg       <= '0;
      r_bit_cnt     <= '0;
      r_dacdat      <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
      if (w_accept) r_hold_full <= 1'b1;

      // LR edges take priority: the coincident BCLK fall belongs to the slot change.
      if (w_lr_fall) begin
        if (r_hold_full) r_hold_full <= 1'b0;
        else             r_underrun  <= 1'b1;
        r_frame_start <= 1'b1;
        r_shreg       <= w_load_word;
        r_bit_cnt     <= CW'(N);
        r_dacdat      <= 1'b0;
        r_state       <= DELAY;
      end else if (w_lr_rise && r_state != IDLE) begin
        r_shreg   <= r_frame;
        r_bit_cnt <= CW'(N);
        r_dacdat  <= 1'b0;
        r_state   <= DELAY;
      end else if (w_bclk_fall) begin
        case (r_state)
          DELAY: begin
            r_dacdat  <= r_shreg[N-1];
            r_shreg   <= r_shreg << 1;
            r_bit_cnt <= r_bit_cnt - CW'(1);
            r_state   <= SHIFT;
          end
          SHIFT: begin
            if (r_bit_cnt != '0) begin
              r_dacdat  <= r_shreg[N-1];
              r_shreg   <= r_shreg << 1;
              r_bit_cnt <= r_bit_cnt - CW'(1);
            end else begin
              r_dacdat <= 1'b0;
              r_state  <= PAD;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign dacdat      = r_dacdat;
  assign frame_start = r_frame_start;
  assign underrun    = r_underrun;

  // w_bclk_rise is not needed: data only moves on falling BCLK.
  logic w_unused;
  assign w_unused = w_bclk_rise;

endmodule

// File: tb/tb_dac_i2s_tx.sv
// Directed bench: codec-master model (BCLK = 16 clk, 32 BCLKs per slot) and
// a slot monitor that samples dacdat on every BCLK rising edge.
module tb_dac_i2s_tx;

  localparam int N = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                bclk = 1'b0;
  logic                daclrck = 1'b0;
  logic signed [N-1:0] sample_data = '0;
  logic                sample_valid = 1'b0;
  logic                sample_ready;
  logic                dacdat;
  logic                frame_start;
  logic                underrun;

  int          n_checks = 0;
  int          n_err = 0;
  int          ur_cnt = 0;
  int          fs_cnt = 0;
  logic [31:0] q_slot[$];
  int          last_left_idx = 0;
  int          mon_pos = 0;
  logic [31:0] mon_sh = '0;
  int          bcnt = 0;

  dac_i2s_tx #(.N(N), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .bclk        (bclk),
    .daclrck     (daclrck),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .dacdat      (dacdat),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  initial forever #5 clk = ~clk;

  // Codec: BCLK toggles every 8 clk; DACLRCK changes with the 32nd falling BCLK.
  initial forever begin
    repeat (8) @(negedge clk);
    bclk = ~bclk;
    if (!bclk) begin
      bcnt++;
      if (bcnt == 32) begin
        bcnt    = 0;
        daclrck = ~daclrck;
      end
    end
  end

  initial forever begin
    @(posedge bclk);
    mon_sh = {mon_sh[30:0], dacdat};
    mon_pos++;
    if (mon_pos == 32) q_slot.push_back(mon_sh);
  end

  initial forever begin
    @(daclrck);
    mon_pos = 0;
    if (!daclrck) last_left_idx = q_slot.size();
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (underrun === 1'b1)    ur_cnt++;
    if (frame_start === 1'b1) fs_cnt++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
    $fatal(1);
  end

  // Slot bit 31 is BCLK 1 (the I2S delay bit), the sample follows MSB-first.
  function automatic logic [31:0] slot_word(input logic [15:0] s);
    return {1'b0, s, 15'b0};
  endfunction

  task automatic offer(input logic [15:0] s);
    int n;
    n = 0;
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = s;
    while (!sample_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!sample_ready) begin
      n_checks++; n_err++;
      $display("FAIL offer_timeout data=%h ready=%b required=1", s, sample_ready);
    end
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic wait_slots(input int target);
    int n;
    n = 0;
    while (q_slot.size() < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (q_slot.size() < target) begin
      n_checks++; n_err++;
      $display("FAIL slot_timeout got=%0d slots required=%0d", q_slot.size(), target);
    end
  endtask

  task automatic test_reset;
    int bad, n;
    @(negedge daclrck);
    repeat (2) @(negedge clk);
    n_checks++; if (dacdat !== 1'b0) begin n_err++; $display("FAIL rst_dacdat got=%b exp=0", dacdat); end
    n_checks++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL rst_frame_start got=%b exp=0", frame_start); end
    n_checks++; if (underrun !== 1'b0) begin n_err++; $display("FAIL rst_underrun got=%b exp=0", underrun); end
    n_checks++; if (sample_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready got=%b exp=1", sample_ready); end
    // Release during the right slot so the lr_rise is detected while IDLE.
    @(posedge daclrck);
    reset  = 1'b0;
    ur_cnt = 0;
    fs_cnt = 0;
    offer(16'hA5C3);
    bad = 0;
    n = 0;
    while (daclrck && n < 1000) begin
      @(negedge clk);
      if (dacdat !== 1'b0) bad++;
      n++;
    end
    n_checks++; if (bad != 0) begin n_err++; $display("FAIL idle_before_lr_fall got=%0d nonzero clks exp=0", bad); end
  endtask

  task automatic test_first_frame;
    int f;
    @(posedge bclk);
    f = last_left_idx;
    wait_slots(f + 2);
    n_checks++; if (q_slot[f] !== slot_word(16'hA5C3)) begin n_err++; $display("FAIL first_left got=%h exp=%h", q_slot[f], slot_word(16'hA5C3)); end
    n_checks++; if (q_slot[f+1] !== slot_word(16'hA5C3)) begin n_err++; $display("FAIL first_right got=%h exp=%h", q_slot[f+1], slot_word(16'hA5C3)); end
    n_checks++; if (ur_cnt != 0) begin n_err++; $display("FAIL first_underrun got=%0d exp=0", ur_cnt); end
    n_checks++; if (fs_cnt != 1) begin n_err++; $display("FAIL first_frame_start got=%0d exp=1", fs_cnt); end
    n_checks++; if (sample_ready !== 1'b1) begin n_err++; $display("FAIL first_ready got=%b exp=1", sample_ready); end
  endtask

  task automatic test_underrun;
    int f;
    ur_cnt = 0;
    fs_cnt = 0;
    @(negedge daclrck);
    @(posedge bclk);
    f = last_left_idx;
    wait_slots(f + 4);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (q_slot[f+i] !== 32'h0) begin n_err++; $display("FAIL underrun_slot%0d got=%h exp=00000000", i, q_slot[f+i]); end
    end
    n_checks++; if (ur_cnt != 2) begin n_err++; $display("FAIL underrun_count got=%0d exp=2", ur_cnt); end
    n_checks++; if (fs_cnt != 2) begin n_err++; $display("FAIL underrun_frame_start got=%0d exp=2", fs_cnt); end
  endtask

  task automatic test_back_to_back;
    int f;
    logic [31:0] exp [6];
    exp = '{slot_word(16'h8000), slot_word(16'h8000), slot_word(16'h7FFF),
            slot_word(16'h7FFF), 32'h0, 32'h0};
    offer(16'h8000);
    n_checks++; if (sample_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_after_accept got=%b exp=0", sample_ready); end
    offer(16'h7FFF);
    f = last_left_idx;
    n_checks++; if (sample_ready !== 1'b0) begin n_err++; $display("FAIL b2b_ready_second got=%b exp=0", sample_ready); end
    wait_slots(f + 6);
    for (int i = 0; i < 6; i++) begin
      n_checks++;
      if (q_slot[f+i] !== exp[i]) begin n_err++; $display("FAIL b2b_slot%0d got=%h exp=%h", i, q_slot[f+i], exp[i]); end
    end
  endtask

  task automatic test_accept_on_load;
    int f;
    @(negedge daclrck);
    n_checks++; if (sample_ready !== 1'b1) begin n_err++; $display("FAIL aol_ready got=%b exp=1", sample_ready); end
    // Valid sits exactly on the clk edge where the synchronised lr_fall acts.
    repeat (2) @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = 16'h1234;
    ur_cnt = 0;
    fs_cnt = 0;
    @(negedge clk);
    sample_valid = 1'b0;
    @(posedge bclk);
    f = last_left_idx;
    wait_slots(f + 4);
    n_checks++; if (q_slot[f] !== 32'h0) begin n_err++; $display("FAIL aol_left0 got=%h exp=00000000", q_slot[f]); end
    n_checks++; if (q_slot[f+1] !== 32'h0) begin n_err++; $display("FAIL aol_right0 got=%h exp=00000000", q_slot[f+1]); end
    n_checks++; if (q_slot[f+2] !== slot_word(16'h1234)) begin n_err++; $display("FAIL aol_left1 got=%h exp=%h", q_slot[f+2], slot_word(16'h1234)); end
    n_checks++; if (q_slot[f+3] !== slot_word(16'h1234)) begin n_err++; $display("FAIL aol_right1 got=%h exp=%h", q_slot[f+3], slot_word(16'h1234)); end
    n_checks++; if (ur_cnt != 1) begin n_err++; $display("FAIL aol_underrun got=%0d exp=1", ur_cnt); end
    n_checks++; if (fs_cnt != 2) begin n_err++; $display("FAIL aol_frame_start got=%0d exp=2", fs_cnt); end
  endtask

  task automatic test_reset_mid_frame;
    int f;
    offer(16'hFFFF);
    @(negedge daclrck);
    @(posedge bclk);
    f = last_left_idx;
    offer(16'h1111);
    repeat (7) @(posedge bclk);
    n_checks++; if (dacdat !== 1'b1) begin n_err++; $display("FAIL mid_before_reset got=%b exp=1", dacdat); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++; if (dacdat !== 1'b0) begin n_err++; $display("FAIL mid_after_reset got=%b exp=0", dacdat); end
    n_checks++; if (sample_ready !== 1'b1) begin n_err++; $display("FAIL mid_hold_discarded got=%b exp=1", sample_ready); end
    offer(16'hC3A5);
    wait_slots(f + 4);
    n_checks++; if (q_slot[f] !== 32'h7F000000) begin n_err++; $display("FAIL mid_left_trunc got=%h exp=7f000000", q_slot[f]); end
    n_checks++; if (q_slot[f+1] !== 32'h0) begin n_err++; $display("FAIL mid_right_silent got=%h exp=00000000", q_slot[f+1]); end
    n_checks++; if (q_slot[f+2] !== slot_word(16'hC3A5)) begin n_err++; $display("FAIL mid_resume_left got=%h exp=%h", q_slot[f+2], slot_word(16'hC3A5)); end
    n_checks++; if (q_slot[f+3] !== slot_word(16'hC3A5)) begin n_err++; $display("FAIL mid_resume_right got=%h exp=%h", q_slot[f+3], slot_word(16'hC3A5)); end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_underrun();
    test_back_to_back();
    test_accept_on_load();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
